// File: rtl/cpu7_inst_resp_pkg.sv
// cpu7_inst_resp_pkg
//   Shared definitions for the instruction-fetch responder.
//   - GRLEN          : width of the returned instruction bus
//   - EXCCODE_ADEF   : exception code for a misaligned fetch address
//   - exccode_e      : exception codes the responder can emit
//   - is_misaligned(): byte-offset test for a fetch address
//   Request entries carried through the request FIFO are laid out as
//   {misaligned, word_addr}, i.e. ADDR_W+1 bits with the flag in the MSB.
package cpu7_inst_resp_pkg;

  localparam int GRLEN = 32;

  localparam logic [5:0] EXCCODE_ADEF = 6'h08;

  typedef enum logic [5:0] {
    EXC_NONE = 6'h00,
    EXC_ADEF = EXCCODE_ADEF
  } exccode_e;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return |byte_off;
  endfunction

endpackage

// File: rtl/cpu7_inst_resp_if.sv
// cpu7_inst_resp_if
//   Instruction-fetch request/response bus between the fetch unit (master)
//   and the responder (slave).
//   Request : inst_req, inst_addr, inst_cancel (master -> slave)
//             inst_addr_ok                     (slave -> master)
//   Response: inst_valid_f, inst_rdata_f, inst_count, inst_ex,
//             inst_exccode, inst_uncache       (slave -> master)
interface cpu7_inst_resp_if;
  import cpu7_inst_resp_pkg::*;

  logic             inst_req;
  logic [31:0]      inst_addr;
  logic             inst_addr_ok;
  logic             inst_cancel;
  logic             inst_valid_f;
  logic [GRLEN-1:0] inst_rdata_f;
  logic [1:0]       inst_count;
  logic             inst_ex;
  logic [5:0]       inst_exccode;
  logic             inst_uncache;

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_valid_f, inst_rdata_f, inst_count,
           inst_ex, inst_exccode, inst_uncache
  );

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_valid_f, inst_rdata_f, inst_count,
           inst_ex, inst_exccode, inst_uncache
  );

endinterface

// File: rtl/cpu7_inst_resp_fifo.sv
// cpu7_inst_resp_fifo
//   Synchronous request FIFO with flush.
//   clock, resetn : clock, asynchronous active-low reset
//   flush_i       : drop all stored entries (a push in the same cycle survives)
//   push_i/wdata_i: write an entry (caller keeps push off when full unless popping)
//   pop_i         : retire the head (caller keeps pop off when empty)
//   rdata_o       : head entry
//   full_o/empty_o: occupancy flags
module cpu7_inst_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 15
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      // A push alongside a flush is newer than everything flushed.
      rd_ptr_q <= '0;
      if (push_i) begin
        mem_q[0] <= wdata_i;
        wr_ptr_q <= PTR_W'(1);
        count_q  <= (PTR_W+1)'(1);
      end else begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/cpu7_inst_resp.sv
// cpu7_inst_resp
//   Responder end of the instruction-fetch interface, in front of a
//   synchronous instruction SRAM (data valid the cycle after ram_en).
//   clock, resetn   : clock, asynchronous active-low reset
//   bus (slave)     : fetch request/response handshake
//   wait_cycles     : per-request issue delay (only with CPU7_INST_RESP_WAIT_EN)
//   ram_en/ram_addr : SRAM read strobe and word address
//   ram_rdata       : SRAM read data
//   Optional feature macro: CPU7_INST_RESP_WAIT_EN adds a programmable wait
//   before each head request is issued; without it requests issue at once.
module cpu7_inst_resp
  import cpu7_inst_resp_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int MAX_OUTST = 2,
  parameter int UNCACHE   = 1
) (
  input  logic              clock,
  input  logic              resetn,
  cpu7_inst_resp_if.slave   bus,
`ifdef CPU7_INST_RESP_WAIT_EN
  input  logic [3:0]        wait_cycles,
`endif
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_rdata
);

  localparam int ENTRY_W = ADDR_W + 1;

  logic               accept;
  logic               cancel;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_fifo;
  logic [ENTRY_W-1:0] head_entry;
  logic               head_valid;
  logic               head_mis;
  logic               use_bypass;
  logic               issue;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               rsp_valid_q;
  logic               rsp_ex_q;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^bus.inst_addr[31:ADDR_W+2];

  assign cancel   = bus.inst_cancel;
  assign accept   = bus.inst_req & ~fifo_full;
  assign in_entry = {is_misaligned(bus.inst_addr[1:0]), bus.inst_addr[ADDR_W+1:2]};

  // On cancel the stored entries are being flushed, so only the request
  // arriving this cycle can be the head; otherwise an empty FIFO lets the
  // incoming request go straight to issue.
  assign use_bypass = cancel | fifo_empty;
  assign head_valid = use_bypass ? accept : 1'b1;
  assign head_entry = use_bypass ? in_entry : head_fifo;
  assign head_mis   = head_entry[ADDR_W];

`ifdef CPU7_INST_RESP_WAIT_EN
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_rem;
  logic       armed_q;
  logic       armed_eff;

  // armed_q marks that the current head already loaded its delay.
  assign armed_eff = armed_q & ~cancel;
  assign wait_rem  = armed_eff ? wait_cnt_q : wait_cycles;
  assign issue     = head_valid & (wait_rem == 4'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      armed_q    <= 1'b0;
      wait_cnt_q <= 4'd0;
    end else if (head_valid & ~issue) begin
      armed_q    <= 1'b1;
      wait_cnt_q <= wait_rem - 4'd1;
    end else begin
      armed_q    <= 1'b0;
      wait_cnt_q <= 4'd0;
    end
  end
`else
  assign issue = head_valid;
`endif

  assign fifo_push = accept & ~(use_bypass & issue);
  assign fifo_pop  = issue & ~use_bypass;

  cpu7_inst_resp_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .flush_i (cancel),
    .push_i  (fifo_push),
    .wdata_i (in_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_fifo),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Misaligned requests occupy the response slot but never touch the SRAM.
  assign ram_en   = issue & ~head_mis;
  assign ram_addr = head_entry[ADDR_W-1:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      rsp_ex_q    <= 1'b0;
    end else begin
      rsp_valid_q <= issue;
      rsp_ex_q    <= issue & head_mis;
    end
  end

  assign bus.inst_addr_ok = accept;
  assign bus.inst_valid_f = rsp_valid_q;
  assign bus.inst_rdata_f = (rsp_valid_q & ~rsp_ex_q) ? GRLEN'(ram_rdata) : '0;
  assign bus.inst_count   = rsp_valid_q ? 2'd1 : 2'd0;
  assign bus.inst_ex      = rsp_ex_q;
  assign bus.inst_exccode = rsp_ex_q ? EXC_ADEF : EXC_NONE;
  assign bus.inst_uncache = 1'(UNCACHE);

endmodule

// File: tb/tb_cpu7_inst_resp.sv
module tb_cpu7_inst_resp;
  import cpu7_inst_resp_pkg::*;

  localparam int ADDR_W = 14;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  cpu7_inst_resp_if bus();

  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
`ifdef CPU7_INST_RESP_WAIT_EN
  logic [3:0]        wait_cycles = 4'd0;
`endif

  cpu7_inst_resp #(
    .ADDR_W    (ADDR_W),
    .MAX_OUTST (2),
    .UNCACHE   (1)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus),
`ifdef CPU7_INST_RESP_WAIT_EN
    .wait_cycles (wait_cycles),
`endif
    .ram_en      (ram_en),
    .ram_addr    (ram_addr),
    .ram_rdata   (ram_rdata)
  );

  // SRAM contents: word 0 holds a real instruction, others are tagged with
  // their own word address.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a == '0) ? 32'h02800421 : {16'hC0DE, 2'b00, a};
  endfunction

  always @(posedge clock) if (ram_en) ram_rdata <= mem_word(ram_addr);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        ex;
    logic [5:0]  code;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response presented by the DUT is matched against the
  // oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn) begin
        if (bus.inst_valid_f === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("unexpected_rsp_valid", bus.inst_valid_f, 0);
          end else begin
            e = sb_q.pop_front();
            check("rsp_rdata", bus.inst_rdata_f, e.rdata);
            check("rsp_ex", bus.inst_ex, e.ex);
            check("rsp_exccode", bus.inst_exccode, e.code);
            check("rsp_count", bus.inst_count, 1);
            if (e.due != 0) check("rsp_cycle", cyc, e.due);
          end
        end else begin
          check("idle_count", bus.inst_count, 0);
        end
      end
    end
  end

  // Drive one request (held until accepted). due_off = cycles from the accept
  // cycle to the response cycle, or 0 when the timing is not checked.
  task automatic send(input logic [31:0] addr, input logic cxl, input int due_off,
                      input logic [31:0] exp_data, input logic exp_ex,
                      output int lat, output logic en_s, output logic [ADDR_W-1:0] addr_s);
    logic ok;
    exp_t e;
    lat = -1;
    en_s = 1'b0;
    addr_s = '0;
    @(posedge clock); #1;
    bus.inst_req    = 1'b1;
    bus.inst_addr   = addr;
    bus.inst_cancel = cxl;
    for (int k = 0; k < 40; k++) begin
      #2;
      ok     = bus.inst_addr_ok;
      en_s   = ram_en;
      addr_s = ram_addr;
      @(negedge clock); #1;
      if (k == 0 && cxl) sb_q.delete();
      if (ok) begin
        e.rdata = exp_data;
        e.ex    = exp_ex;
        e.code  = exp_ex ? 6'h08 : 6'h00;
        e.due   = (due_off == 0) ? 0 : cyc + due_off;
        sb_q.push_back(e);
        lat = k;
        break;
      end
      @(posedge clock); #1;
      bus.inst_cancel = 1'b0;
    end
    if (lat < 0) check("accept_timeout", bus.inst_addr_ok, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      bus.inst_req    = 1'b0;
      bus.inst_cancel = 1'b0;
    end
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n && sb_q.size() != 0; i++) @(posedge clock);
    check(name, sb_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0]       addr;
    logic              gap;
    logic [31:0]       data;
    logic              ex;
    logic [ADDR_W-1:0] waddr;
  } vec_t;

  vec_t vecs [11] = '{
    '{32'h1C000000, 1'b1, 32'h02800421, 1'b0, 14'h0000},
    '{32'h00000000, 1'b1, 32'h02800421, 1'b0, 14'h0000},
    '{32'h00000004, 1'b0, 32'hC0DE0001, 1'b0, 14'h0001},
    '{32'h00000008, 1'b0, 32'hC0DE0002, 1'b0, 14'h0002},
    '{32'h00000006, 1'b1, 32'h00000000, 1'b1, 14'h0001},
    '{32'h00010008, 1'b1, 32'hC0DE0002, 1'b0, 14'h0002},
    '{32'h0000FFFC, 1'b0, 32'hC0DE3FFF, 1'b0, 14'h3FFF},
    '{32'h00000002, 1'b0, 32'h00000000, 1'b1, 14'h0000},
    '{32'h00000010, 1'b0, 32'hC0DE0004, 1'b0, 14'h0004},
    '{32'hFFFF0014, 1'b1, 32'hC0DE0005, 1'b0, 14'h0005},
    '{32'h00000003, 1'b0, 32'h00000000, 1'b1, 14'h0000}
  };

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int                lat;
    logic              en_s;
    logic [ADDR_W-1:0] ra_s;

    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'h0;
    bus.inst_cancel = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_addr_ok", bus.inst_addr_ok, 0);
    check("rst_valid", bus.inst_valid_f, 0);
    check("rst_ex", bus.inst_ex, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_rdata", bus.inst_rdata_f, 0);
    check("rst_count", bus.inst_count, 0);
    check("rst_exccode", bus.inst_exccode, 0);
    check("rst_uncache", bus.inst_uncache, 1);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].gap) idle(2);
      send(vecs[i].addr, 1'b0, 1, vecs[i].data, vecs[i].ex, lat, en_s, ra_s);
      check($sformatf("v%0d_accept_lat", i), lat, 0);
      check($sformatf("v%0d_ram_en", i), en_s, !vecs[i].ex);
      check($sformatf("v%0d_ram_addr", i), ra_s, vecs[i].waddr);
    end
    idle(3);

    // Cancel with nothing outstanding; the same-cycle request is serviced.
    send(32'h00000040, 1'b1, 1, 32'hC0DE0010, 1'b0, lat, en_s, ra_s);
    check("cancel_idle_accept_lat", lat, 0);
    check("cancel_idle_ram_en", en_s, 1);
    idle(2);

    // Cancel while a response is on the bus: that response is still shown.
    send(32'h00000008, 1'b0, 1, 32'hC0DE0002, 1'b0, lat, en_s, ra_s);
    @(posedge clock); #1;
    bus.inst_req    = 1'b0;
    bus.inst_cancel = 1'b1;
    @(negedge clock); #1;
    check("cancel_presented_rsp", sb_q.size(), 0);
    idle(3);

`ifdef CPU7_INST_RESP_WAIT_EN
    wait_cycles = 4'd2;
    send(32'h00000020, 1'b0, 3, 32'hC0DE0008, 1'b0, lat, en_s, ra_s);
    check("wait2_accept_lat", lat, 0);
    check("wait2_no_early_ram_en", en_s, 0);
    idle(1);
    drain("wait2_drain", 50);

    wait_cycles = 4'd3;
    send(32'h00000010, 1'b0, 0, 32'hC0DE0004, 1'b0, lat, en_s, ra_s);
    send(32'h00000014, 1'b0, 0, 32'hC0DE0005, 1'b0, lat, en_s, ra_s);
    send(32'h00000040, 1'b1, 4, 32'hC0DE0010, 1'b0, lat, en_s, ra_s);
    check("wait3_cancel_new_lat", lat, 1);
    idle(1);
    drain("wait3_cancel_drain", 50);
    idle(10);

    wait_cycles = 4'd15;
    send(32'h00000000, 1'b0, 16, 32'h02800421, 1'b0, lat, en_s, ra_s);
    check("full_first_lat", lat, 0);
    send(32'h00000004, 1'b0, 31, 32'hC0DE0001, 1'b0, lat, en_s, ra_s);
    check("full_second_lat", lat, 0);
    send(32'h00000008, 1'b0, 32, 32'hC0DE0002, 1'b0, lat, en_s, ra_s);
    check("full_third_lat", lat, 14);
    idle(1);
    drain("full_drain", 100);
`endif

    // Reset with requests in flight.
    send(32'h00000004, 1'b0, 0, 32'hC0DE0001, 1'b0, lat, en_s, ra_s);
    send(32'h00000008, 1'b0, 0, 32'hC0DE0002, 1'b0, lat, en_s, ra_s);
    @(posedge clock); #1;
    bus.inst_req = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_valid", bus.inst_valid_f, 0);
    check("midrst_addr_ok", bus.inst_addr_ok, 0);
    check("midrst_ram_en", ram_en, 0);
    check("midrst_ex", bus.inst_ex, 0);
    check("midrst_count", bus.inst_count, 0);
    check("midrst_rdata", bus.inst_rdata_f, 0);
    sb_q.delete();
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (40) @(posedge clock);

    drain("final_drain", 100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
